// File: rtl/cariomart_uart_rx.sv
// cariomart_uart_rx
//   Fabric-side 8N1 UART receiver. The serial line is oversampled at 16x baud.
//   Each good character is pushed into a small first-word-fall-through FIFO,
//   and the fabric reads it over a valid/ready handshake.
//
// Parameters
//   BAUD_DIV    FAB_CLK cycles per oversample tick (2..65535)
//   FIFO_DEPTH  receive FIFO entries (power of two, >= 2)
//
// Ports
//   FAB_CLK      in   fabric clock, rising edge
//   MSS_RESET_N  in   asynchronous active-low reset
//   UART_RXD     in   asynchronous serial input, idles high
//   RX_DATA      out  FIFO head byte, meaningful while RX_VALID
//   RX_VALID     out  FIFO not empty
//   RX_READY     in   consumer pops the head when RX_VALID & RX_READY
//   FRAMING_ERR  out  one-cycle pulse, stop bit sampled low
//   OVERRUN      out  one-cycle pulse, good byte dropped because FIFO full
module cariomart_uart_rx #(
  parameter int BAUD_DIV   = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       FAB_CLK,
  input  logic       MSS_RESET_N,
  input  logic       UART_RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       FRAMING_ERR,
  output logic       OVERRUN
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_e;

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge detect
  // ---------------------------------------------------------------------------
  logic       sync1_q, rxs_q, rxs_prev_q;
  // armed_q fills with ones after reset. rxs_prev_q is trusted only once it
  // holds a sample of the real line. Without this, a line that is already low
  // at reset release would look like a 1->0 edge against the reset value.
  logic [2:0] armed_q;

  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      armed_q    <= '0;
    end else begin
      sync1_q    <= UART_RXD;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      armed_q    <= {armed_q[1:0], 1'b1};
    end
  end

  state_e state_q;
  logic   start_edge;

  assign start_edge = (state_q == S_IDLE) && armed_q[2] && rxs_prev_q && !rxs_q;

  // ---------------------------------------------------------------------------
  // Oversample tick generator. It is realigned on the start edge so that
  // every later sample falls a whole number of ticks after that edge.
  // ---------------------------------------------------------------------------
  logic [15:0] div_q;
  logic        tick;

  assign tick = (div_q == 16'(BAUD_DIV - 1));

  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N)    div_q <= '0;
    else if (start_edge) div_q <= '0;
    else if (tick)       div_q <= '0;
    else                 div_q <= div_q + 16'd1;
  end

  // ---------------------------------------------------------------------------
  // Framing FSM
  // ---------------------------------------------------------------------------
  logic [3:0] tcnt_q;   // ticks within the current bit
  logic [2:0] bidx_q;
  logic [7:0] shift_q;
  logic       ferr_q;
  logic       push;

  // A good stop sample pushes on this cycle's edge, so RX_VALID rises on the
  // very next cycle.
  assign push = (state_q == S_STOP) && tick && (tcnt_q == 4'd15) && rxs_q;

  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      state_q <= S_IDLE;
      tcnt_q  <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_edge) begin
            state_q <= S_START;
            tcnt_q  <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            if (tcnt_q == 4'd7) begin
              // Mid start bit. If the line is high again, it was a glitch.
              tcnt_q <= '0;
              if (!rxs_q) begin
                state_q <= S_DATA;
                bidx_q  <= '0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            tcnt_q <= tcnt_q + 4'd1;  // wraps 15 -> 0 at each bit centre
            if (tcnt_q == 4'd15) begin
              shift_q[bidx_q] <= rxs_q;
              bidx_q          <= bidx_q + 3'd1;
              if (bidx_q == 3'd7) state_q <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            tcnt_q <= tcnt_q + 4'd1;
            if (tcnt_q == 4'd15) begin
              // Leave at mid stop bit so a tight next start edge is not missed.
              if (rxs_q) begin
                state_q <= S_IDLE;
              end else begin
                state_q <= S_BREAK;
                ferr_q  <= 1'b1;
              end
            end
          end
        end
        S_BREAK: begin
          if (rxs_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;   // power-of-two depth: natural wrap
  logic [PW-1:0] count_q, count_d;
  logic          ovr_q;
  logic          full, pop, wr_en;

  assign full     = (count_q == PW'(FIFO_DEPTH));
  assign RX_VALID = (count_q != '0);
  assign pop      = RX_VALID && RX_READY;
  // When full, a push fits only if the head leaves in the same cycle.
  assign wr_en    = push && (!full || pop);
  assign RX_DATA  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
  end

  // The storage is reset as well, so RX_DATA reads 8'h00 after reset.
  always_ff @(posedge FAB_CLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      ovr_q <= push && full && !pop;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign FRAMING_ERR = ferr_q;
  assign OVERRUN     = ovr_q;

endmodule

// File: tb/tb_cariomart_uart_rx.sv
// tb_cariomart_uart_rx
//   Directed bench for cariomart_uart_rx with BAUD_DIV=4 (one bit = 64 cycles).
//   The serial line is driven cycle-exactly from posedge+1. Outputs are
//   sampled on the falling edge.
module tb_cariomart_uart_rx;
  localparam int BD  = 4;
  localparam int BIT = 16 * BD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rdy = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, ovr;

  always #5 clk = ~clk;

  cariomart_uart_rx #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
    .FAB_CLK    (clk),
    .MSS_RESET_N(rst_n),
    .UART_RXD   (rxd),
    .RX_DATA    (data),
    .RX_VALID   (valid),
    .RX_READY   (rdy),
    .FRAMING_ERR(ferr),
    .OVERRUN    (ovr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int f0, o0;

  // Every high cycle is counted, so a stretched pulse shows up as a count > 1.
  always @(negedge clk) begin
    if (ferr) ferr_cnt++;
    if (ovr)  ovr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic level(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_head(input logic [7:0] b);
    level(1'b0, BIT);
    for (int i = 0; i < 8; i++) level(b[i], BIT);
  endtask

  task automatic tx_byte(input logic [7:0] b);
    tx_head(b);
    level(1'b1, BIT);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk({tag, "_vld"}, 32'(valid), 32'd1);
    chk(tag, 32'(data), 32'(exp));
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  initial begin
    // ---- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld",  32'(valid), 32'd0);
    chk("rst_data", 32'(data),  32'h00);
    chk("rst_ferr", 32'(ferr),  32'd0);
    chk("rst_ovr",  32'(ovr),   32'd0);
    rst_n = 1'b1;
    level(1'b1, 20);

    // ---- 1: single byte, exact latency
    f0 = ferr_cnt; o0 = ovr_cnt;
    tx_head(8'hA5);
    rxd = 1'b1;
    repeat (34) @(posedge clk);            // stop-sample cycle
    @(negedge clk);
    chk("t1_vld_early", 32'(valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_vld",  32'(valid), 32'd1);
    chk("t1_data", 32'(data),  32'hA5);
    level(1'b1, 40);
    pop_chk("t1_pop", 8'hA5);
    chk("t1_empty", 32'(valid), 32'd0);
    chk("t1_noerr", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);

    // ---- 2: glitch
    f0 = ferr_cnt; o0 = ovr_cnt;
    level(1'b0, 20);
    level(1'b1, 200);
    @(negedge clk);
    chk("t2_vld",  32'(valid), 32'd0);
    chk("t2_ferr", ferr_cnt - f0, 32'd0);
    chk("t2_ovr",  ovr_cnt - o0,  32'd0);

    // ---- 3: framing error, then recovery
    level(1'b1, 20);
    f0 = ferr_cnt;
    tx_head(8'h00);
    level(1'b0, 3 * BIT);
    level(1'b1, BIT);
    @(negedge clk);
    chk("t3_ferr", ferr_cnt - f0, 32'd1);
    chk("t3_vld",  32'(valid), 32'd0);
    level(1'b1, 10);
    tx_byte(8'h3C);
    pop_chk("t3_next", 8'h3C);
    chk("t3_empty", 32'(valid), 32'd0);

    // ---- 4: overrun
    level(1'b1, 20);
    f0 = ferr_cnt; o0 = ovr_cnt;
    for (int i = 1; i <= 4; i++) tx_byte(8'(i));
    chk("t4_ovr_pre", ovr_cnt - o0, 32'd0);
    tx_byte(8'h05);
    chk("t4_ovr", ovr_cnt - o0, 32'd1);
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("t4_drain%0d", i), 8'(i));
    chk("t4_empty", 32'(valid), 32'd0);
    chk("t4_ferr",  ferr_cnt - f0, 32'd0);

    // ---- 5: full FIFO, push and pop on the same cycle
    level(1'b1, 20);
    o0 = ovr_cnt;
    for (int i = 1; i <= 4; i++) tx_byte(8'(i));
    tx_head(8'h55);
    rxd = 1'b1;
    repeat (34) @(posedge clk);
    #1 rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
    level(1'b1, 40);
    chk("t5_ovr", ovr_cnt - o0, 32'd0);
    pop_chk("t5_d0", 8'h02);
    pop_chk("t5_d1", 8'h03);
    pop_chk("t5_d2", 8'h04);
    pop_chk("t5_d3", 8'h55);
    chk("t5_empty", 32'(valid), 32'd0);

    // ---- 6: reset mid-frame with a byte already buffered
    level(1'b1, 20);
    tx_byte(8'h77);
    @(negedge clk);
    chk("t6_pre_vld", 32'(valid), 32'd1);
    level(1'b1, 5);
    f0 = ferr_cnt; o0 = ovr_cnt;
    fork
      tx_byte(8'hFF);
      begin
        repeat (5 * BIT + BIT / 2) @(posedge clk);   // middle of data bit 4
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rst_vld",  32'(valid), 32'd0);
        chk("t6_rst_data", 32'(data),  32'h00);
      end
    join
    level(1'b1, 20);
    chk("t6_vld",  32'(valid), 32'd0);
    chk("t6_errs", 32'(ferr_cnt - f0 + ovr_cnt - o0), 32'd0);
    tx_byte(8'h81);
    pop_chk("t6_next", 8'h81);
    chk("t6_empty", 32'(valid), 32'd0);

    // ---- 7: line already low at reset release is not a start edge
    f0 = ferr_cnt;
    rxd = 1'b0;
    rst_n = 1'b0;
    level(1'b0, 5);
    rst_n = 1'b1;
    level(1'b0, 700);
    level(1'b1, BIT);
    @(negedge clk);
    chk("t7_vld",  32'(valid), 32'd0);
    chk("t7_ferr", ferr_cnt - f0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
